instr_fetch_unit: RTL

//  Fetch stage directly upstream of the immediate-extension/decode logic.
//  - Owns the 64-bit PC and reads 32-bit instructions over a req/ack imem interface.
//  - Latches each word into the instruction register (IR).
//  - Presents the IR and its PC to decode with a valid/ready handshake.
//  - Accepts branch/jump redirects from execute.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/ir_hold_reg.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INSN_W = 32;
    localparam int XLEN   = 64;

    localparam logic [XLEN-1:0]   PC_STEP    = 64'd4;
    localparam logic [XLEN-1:0]   ALIGN_MASK = ~64'd3;
    localparam logic [INSN_W-1:0] OPC_NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ir_hold_reg.sv
// Instruction register: the fetched word, its PC and the valid flag presented to decode.
module ir_hold_reg
    import fetch_pkg::*;
#(
    parameter logic [INSN_W-1:0] NOP_INSN = OPC_NOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic              consume,
    input  logic [INSN_W-1:0] load_insn,
    input  logic [XLEN-1:0]   load_pc,
    output logic              ir_valid,
    output logic [INSN_W-1:0] ir_out,
    output logic [XLEN-1:0]   ir_pc
);

    logic              valid_reg;
    logic [INSN_W-1:0] insn_reg;
    logic [XLEN-1:0]   pc_reg;

    // A flush and a consume both just drop valid; the word stays for debug visibility.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            insn_reg  <= NOP_INSN;
            pc_reg    <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            insn_reg  <= load_insn;
            pc_reg    <= load_pc;
        end else if (clear || consume) begin
            valid_reg <= 1'b0;
        end
    end

    assign ir_valid = valid_reg;
    assign ir_out   = insn_reg;
    assign ir_pc    = pc_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request FSM, redirect handling, IR to decode.
// Optional misaligned-redirect trap is built when MISALIGN_TRAP_EN is defined.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_0000_0000,
    parameter logic [INSN_W-1:0] NOP_INSN = OPC_NOP
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [INSN_W-1:0] ir_out,
    output logic [XLEN-1:0]   ir_pc,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              fetch_fault
);

    fetch_state_e    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            redir_pend_reg, redir_pend_next;
    logic [XLEN-1:0] redir_tgt_reg, redir_tgt_next;
    logic            req_int;
    logic            ir_load, ir_clear, ir_consume;
    logic [XLEN-1:0] sel_tgt;
    logic [XLEN-1:0] target_pc;

    // A redirect arriving this cycle beats one latched earlier.
    assign sel_tgt = redirect_valid ? redirect_pc : redir_tgt_reg;

`ifdef MISALIGN_TRAP_EN
    logic fault_reg, fault_next;
    logic tgt_misaligned;

    assign target_pc      = sel_tgt;
    assign tgt_misaligned = (sel_tgt[1:0] != 2'b00);
    assign fetch_fault    = fault_reg;
`else
    assign target_pc   = sel_tgt & ALIGN_MASK;
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_REQ;
            pc_reg         <= RESET_PC;
            redir_pend_reg <= 1'b0;
            redir_tgt_reg  <= '0;
`ifdef MISALIGN_TRAP_EN
            fault_reg      <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            redir_pend_reg <= redir_pend_next;
            redir_tgt_reg  <= redir_tgt_next;
`ifdef MISALIGN_TRAP_EN
            fault_reg      <= fault_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        redir_pend_next = redir_pend_reg;
        redir_tgt_next  = redir_tgt_reg;
        req_int         = 1'b0;
        ir_load         = 1'b0;
        ir_clear        = 1'b0;
        ir_consume      = 1'b0;
`ifdef MISALIGN_TRAP_EN
        fault_next      = fault_reg;
`endif
        case (state_reg)
            S_REQ: begin
                req_int = 1'b1;
                if (imem_ack) begin
                    if (redirect_valid || redir_pend_reg) begin
                        // Returned word belongs to the abandoned path; drop it.
                        redir_pend_next = 1'b0;
                        pc_next         = target_pc;
`ifdef MISALIGN_TRAP_EN
                        if (tgt_misaligned) begin
                            state_next = S_FAULT;
                            fault_next = 1'b1;
                        end
`endif
                    end else begin
                        ir_load    = 1'b1;
                        pc_next    = pc_reg + PC_STEP;
                        state_next = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    redir_pend_next = 1'b1;
                    redir_tgt_next  = redirect_pc;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    ir_clear   = 1'b1;
                    pc_next    = target_pc;
                    state_next = S_REQ;
`ifdef MISALIGN_TRAP_EN
                    if (tgt_misaligned) begin
                        state_next = S_FAULT;
                        fault_next = 1'b1;
                    end
`endif
                end else if (ir_ready) begin
                    ir_consume = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_FAULT: begin
`ifdef MISALIGN_TRAP_EN
                if (redirect_valid && !tgt_misaligned) begin
                    pc_next    = target_pc;
                    fault_next = 1'b0;
                    state_next = S_REQ;
                end
`else
                state_next = S_REQ;
`endif
            end
            default: state_next = S_REQ;
        endcase
    end

    // Request drops immediately on reset even though the state reads S_REQ.
    assign imem_req  = req_int & ~reset;
    assign imem_addr = pc_reg;

    ir_hold_reg #(
        .NOP_INSN (NOP_INSN)
    ) u_ir_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (ir_load),
        .clear     (ir_clear),
        .consume   (ir_consume),
        .load_insn (imem_rdata),
        .load_pc   (pc_reg),
        .ir_valid  (ir_valid),
        .ir_out    (ir_out),
        .ir_pc     (ir_pc)
    );

endmodule
